// File: rtl/cafeteira_pedido.sv
// Order front-end for the coffee dispenser: collects coins, validates a drink
// selection against its price, supervises the dispenser and returns change.
module cafeteira_pedido #(
  parameter int PRECO_CURTO = 2,
  parameter int PRECO_LONGO = 3,
  parameter int PRECO_LEITE = 4,
  parameter int TIMEOUT     = 16,
  parameter int CREDITO_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       moeda,
  input  logic [1:0] sel,
  input  logic       sel_valida,
  input  logic       cancela,
  input  logic       c,
  input  logic       l,
  input  logic       f,
  output logic [1:0] tipo,
  output logic       maq_rst,
  output logic       ocupado,
  output logic [3:0] credito,
  output logic       troco,
  output logic       pronto,
  output logic       erro
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] CRED_MAX   = 4'(CREDITO_MAX);
  localparam logic [4:0] CRED_MAX5  = 5'(CREDITO_MAX);
  localparam logic [WD_W-1:0] WD_FIM = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    PREPARO = 3'd1,
    ENTREGA = 3'd2,
    TROCO   = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  estado_t         state;
  estado_t         next_state;
  logic [3:0]      preco_reg;
  logic [WD_W-1:0] watchdog;

  logic [3:0]      credito_next;
  logic [1:0]      tipo_next;
  logic [3:0]      preco_next;
  logic [WD_W-1:0] watchdog_next;
  logic            troco_next;
  logic [3:0]      preco_sel;
  logic [3:0]      credito_moeda;

  // The coffee-phase indicator is observed only; nothing in the order flow depends on it.
  logic unused_monitor;
  assign unused_monitor = c;

  function automatic logic [3:0] preco_de(input logic [1:0] codigo);
    logic [3:0] p;
    case (codigo)
      2'b00:   p = 4'(PRECO_CURTO);
      2'b01:   p = 4'(PRECO_LONGO);
      2'b10:   p = 4'(PRECO_LEITE);
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] satura(input logic [4:0] valor);
    logic [3:0] r;
    if (valor > CRED_MAX5) begin
      r = CRED_MAX;
    end else begin
      r = valor[3:0];
    end
    return r;
  endfunction

  // Next-state, credit bookkeeping and change pulses.
  always_comb begin
    next_state    = state;
    credito_next  = credito;
    tipo_next     = tipo;
    preco_next    = preco_reg;
    watchdog_next = watchdog;
    troco_next    = 1'b0;
    preco_sel     = preco_de(sel);
    if (moeda && (credito != CRED_MAX)) begin
      credito_moeda = credito + 4'd1;
    end else begin
      credito_moeda = credito;
    end

    case (state)
      ESPERA: begin
        credito_next = credito_moeda;
        if (cancela) begin
          if (credito != 4'd0) begin
            next_state = TROCO;
          end else begin
            next_state = ESPERA;
          end
        end else if (sel_valida && (sel != 2'b11) && (credito >= preco_sel)) begin
          // Price is checked against the credit held before this cycle's coin.
          tipo_next     = sel;
          preco_next    = preco_sel;
          credito_next  = credito - preco_sel + {3'b000, moeda};
          watchdog_next = '0;
          next_state    = PREPARO;
        end else begin
          next_state = ESPERA;
        end
      end

      PREPARO: begin
        credito_next  = credito_moeda;
        watchdog_next = watchdog + WD_W'(1);
        if (f) begin
          next_state = ENTREGA;
        end else if ((l && (tipo != 2'b10)) || (watchdog == WD_FIM)) begin
          next_state   = ERRO;
          credito_next = satura({1'b0, credito} + {1'b0, preco_reg});
        end else begin
          next_state = PREPARO;
        end
      end

      ENTREGA: begin
        next_state = ESPERA;
      end

      TROCO: begin
        if (credito != 4'd0) begin
          credito_next = credito - 4'd1;
          troco_next   = 1'b1;
          if (credito == 4'd1) begin
            next_state = ESPERA;
          end else begin
            next_state = TROCO;
          end
        end else begin
          next_state = ESPERA;
        end
      end

      ERRO: begin
        if (cancela) begin
          if (credito != 4'd0) begin
            next_state = TROCO;
          end else begin
            next_state = ESPERA;
          end
        end else begin
          next_state = ERRO;
        end
      end

      default: begin
        next_state = ESPERA;
      end
    endcase
  end

  // State, datapath and registered outputs derived from the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ESPERA;
      credito   <= 4'd0;
      tipo      <= 2'b00;
      preco_reg <= 4'd0;
      watchdog  <= '0;
      maq_rst   <= 1'b1;
      ocupado   <= 1'b0;
      troco     <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      state     <= next_state;
      credito   <= credito_next;
      tipo      <= tipo_next;
      preco_reg <= preco_next;
      watchdog  <= watchdog_next;
      maq_rst   <= (next_state != PREPARO);
      ocupado   <= (next_state == PREPARO) || (next_state == TROCO) || (next_state == ERRO);
      troco     <= troco_next;
      pronto    <= (next_state == ENTREGA);
      erro      <= (next_state == ERRO);
    end
  end

endmodule

// File: doc/cafeteira_pedido.md
Name: cafeteira_pedido

Overview:
- Order front-end that drives the coffee dispenser FSM, which pours coffee (c), then milk (l), then signals finished (f).
- Accepts coin pulses and a drink selection, and checks credit against a per-drink price.
- Releases the dispenser from reset with a stable tipo code, then watches c/l/f until the drink is finished.
- Returns change unit by unit and flags a dispenser timeout.

Parameters:
- PRECO_CURTO, 2: price in credit units for tipo 2'b00 (short coffee).
- PRECO_LONGO, 3: price for tipo 2'b01 (long coffee).
- PRECO_LEITE, 4: price for tipo 2'b10 (coffee with milk).
- TIMEOUT, 16: maximum cycles in PREPARO without f before error.
- CREDITO_MAX, 15: credit saturation value. The credito width is 4 bits.

Ports:
- clock  input  1  Single system clock; all state updates on its rising edge.
- reset  input  1  Synchronous, active-low reset: sampled on posedge clock; reset==0 clears the block.
- moeda  input  1  One-cycle pulse; adds 1 credit unit.
- sel  input  2  Drink selection code; 2'b11 is invalid.
- sel_valida  input  1  One-cycle strobe qualifying sel.
- cancela  input  1  One-cycle pulse; requests refund of the credit.
- c  input  1  Dispenser coffee-phase indicator.
- l  input  1  Dispenser milk-phase indicator.
- f  input  1  Dispenser finished indicator.
- tipo  output  2  Drink code to the dispenser; stable for the whole PREPARO state.
- maq_rst  output  1  Active-high hold on the dispenser; 0 only in PREPARO.
- ocupado  output  1  High in PREPARO, TROCO and ERRO.
- credito  output  4  Current credit units.
- troco  output  1  One pulse per credit unit returned.
- pronto  output  1  One-cycle pulse on drink completion.
- erro  output  1  High while in ERRO.

Behaviour:
- Reset (reset==0 at posedge clock):
  - state=ESPERA, credito=0, tipo=2'b00, maq_rst=1.
  - ocupado=0, troco=0, pronto=0, erro=0, watchdog=0, preco_reg=0.
  - Reset overrides any state, including mid-brew and mid-refund. Any credit held at that moment is discarded.
- All outputs are registered.
- Credit arithmetic:
  - In ESPERA and PREPARO, a moeda pulse adds 1 to credito, saturating at CREDITO_MAX. A coin arriving at saturation is dropped.
  - In TROCO and ERRO, moeda is ignored.
- ESPERA:
  - cancela with credito>0 -> TROCO. cancela with credito==0 does nothing.
  - cancela has priority over sel_valida in the same cycle.
  - sel_valida is accepted only when sel!=2'b11 and credito>=price(sel). Price is evaluated against the credit held before any same-cycle coin.
  - On acceptance, all of the following happen in the same cycle:
    - tipo<=sel, preco_reg<=price.
    - credito<=credito-price+moeda.
    - watchdog<=0, state<=PREPARO.
  - A rejected selection (invalid code or insufficient credit) is ignored with no state change.
- PREPARO:
  - maq_rst=0 and ocupado=1; the first maq_rst low cycle is the cycle after acceptance.
  - watchdog increments every cycle.
  - sel_valida and cancela are ignored.
  - f==1 sampled -> ENTREGA. f has priority over timeout in the same cycle.
  - watchdog==TIMEOUT-1 with f==0 -> ERRO, and credito<=sat(credito+preco_reg).
- ENTREGA:
  - One cycle: pronto=1, maq_rst=1, then -> ESPERA.
  - Remaining credit is kept for the next order.
- TROCO:
  - Each cycle: troco=1 and credito decrements by 1.
  - -> ESPERA in the cycle credito reaches 0.
  - Exactly N troco pulses are produced for N units.
- ERRO:
  - erro=1, maq_rst=1, ocupado=1.
  - Held until cancela: with credito>0 -> TROCO, with credito==0 -> ESPERA.
- c and l are monitored only. If l==1 is seen while tipo!=2'b10, the block goes to ERRO with the same refund rule as a timeout.

Test Plan:
- Reset mid-PREPARO (reset=0 for 1 cycle) -> next cycle: maq_rst=1, credito=0, state ESPERA, no pronto pulse.
- 2 moeda pulses, then sel=00 with sel_valida -> credito 2->0, tipo=00, maq_rst low the next cycle; drive f=1 after 3 cycles -> exactly one pronto pulse, maq_rst=1.
- 3 coins, sel=10 -> rejected, credito stays 3. Then cancela -> exactly 3 troco pulses, credito=0, state ESPERA.
- 5 coins, sel=01 with a moeda in the same cycle -> credito=5-3+1=3. f never asserted -> after 16 cycles erro=1 and credito=6; then cancela -> 6 troco pulses.
- 16 coins -> credito saturates at 15. Same-cycle cancela+sel_valida -> refund path wins, 15 troco pulses.
- sel=01 accepted, dispenser raises l=1 -> ERRO with price refunded; sel=11 with 15 credit -> ignored.
